// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: bundles config, receiver-side and consumer-side signals of the RX control block.
// Latency: none, wiring only.
// Backpressure: carries the out_valid/out_ready handshake; slave = control block, master = its environment.
interface uart_rx_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
);
  // runtime configuration request and applied configuration
  logic                  cfg_wr;
  logic                  cfg_par_en;
  logic                  cfg_par_typ;
  logic [5:0]            cfg_prescale;
  logic                  cfg_pending;
  logic                  cfg_ack;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [5:0]            Prescale;
  logic                  rx_en;
  // receiver back-end
  logic                  rx_busy;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_data_valid;
  logic                  rx_par_err;
  logic                  rx_stp_err;
  // consumer side and statistics
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  fifo_full;
  logic [CNT_WIDTH-1:0]  par_err_cnt;
  logic [CNT_WIDTH-1:0]  stp_err_cnt;
  logic [CNT_WIDTH-1:0]  ovr_cnt;
  logic                  cnt_clr;

  modport slave (
    input  cfg_wr, cfg_par_en, cfg_par_typ, cfg_prescale,
    input  rx_busy, rx_data, rx_data_valid, rx_par_err, rx_stp_err,
    input  out_ready, cnt_clr,
    output cfg_pending, cfg_ack, PAR_EN, PAR_TYP, Prescale, rx_en,
    output out_data, out_valid, fifo_full, par_err_cnt, stp_err_cnt, ovr_cnt
  );

  modport master (
    output cfg_wr, cfg_par_en, cfg_par_typ, cfg_prescale,
    output rx_busy, rx_data, rx_data_valid, rx_par_err, rx_stp_err,
    output out_ready, cnt_clr,
    input  cfg_pending, cfg_ack, PAR_EN, PAR_TYP, Prescale, rx_en,
    input  out_data, out_valid, fifo_full, par_err_cnt, stp_err_cnt, ovr_cnt
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: applies receiver config only between frames, buffers RX words, counts errors/overruns.
// Latency: config visible 3 cycles after cfg_wr with receiver idle; a pushed word is visible 1 cycle later.
// Backpressure: out_valid/out_ready; a word arriving while full and not popped that cycle is dropped and counted.
module uart_rx_ctrl #(
  parameter int         DATA_WIDTH    = 8,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         CNT_WIDTH     = 8,
  parameter logic [5:0] PRESCALE_RST  = 6'd8,
  parameter int         SETTLE_CYCLES = 2
) (
  input logic           CLK,
  input logic           RST,
  uart_rx_ctrl_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [OW-1:0] DEPTH_CNT   = OW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_APPLY, S_SETTLE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_newer;
  logic            w_newer_nxt;
  logic            w_in_apply;
  logic [SW-1:0]   r_settle_cnt;
  logic            r_sh_par_en;
  logic            r_sh_par_typ;
  logic [5:0]      r_sh_prescale;
  logic            r_par_en;
  logic            r_par_typ;
  logic [5:0]      r_prescale;
  logic            r_cfg_ack;
  logic            r_cfg_pending;
  logic            r_rx_en;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [OW-1:0]         r_count;
  logic [OW-1:0]         w_count_nxt;
  logic                  r_out_valid;
  logic                  r_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovr;
  logic [CNT_WIDTH-1:0]  r_par_cnt;
  logic [CNT_WIDTH-1:0]  r_stp_cnt;
  logic [CNT_WIDTH-1:0]  r_ovr_cnt;

  // Saturating event counter; a clear coinciding with an event leaves 1 so the event survives.
  function automatic logic [CNT_WIDTH-1:0] f_cnt_nxt(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic ev, input logic clr);
    if (clr)
      return ev ? CNT_WIDTH'(1) : '0;
    else if (ev && (cnt != '1))
      return cnt + CNT_WIDTH'(1);
    else
      return cnt;
  endfunction

  // Config FSM next state; a request seen in APPLY/SETTLE is remembered and sends us back to WAIT.
  always_comb begin
    w_state_nxt = r_state;
    w_in_apply  = (r_state == S_APPLY) || (r_state == S_SETTLE);
    case (r_state)
      S_IDLE:   if (bus.cfg_wr) w_state_nxt = S_WAIT;
      S_WAIT:   if (!bus.rx_busy) w_state_nxt = S_APPLY;
      S_APPLY:  w_state_nxt = S_SETTLE;
      S_SETTLE: if (r_settle_cnt == '0) w_state_nxt = (r_newer || bus.cfg_wr) ? S_WAIT : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
    w_newer_nxt = ((w_state_nxt == S_APPLY) || (w_state_nxt == S_SETTLE)) &&
                  (r_newer || (bus.cfg_wr && w_in_apply));
  end

  // Config state, shadow/applied registers and registered FSM outputs (decoded from next state).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_newer       <= 1'b0;
      r_settle_cnt  <= '0;
      r_sh_par_en   <= 1'b1;
      r_sh_par_typ  <= 1'b0;
      r_sh_prescale <= PRESCALE_RST;
      r_par_en      <= 1'b1;
      r_par_typ     <= 1'b0;
      r_prescale    <= PRESCALE_RST;
      r_cfg_ack     <= 1'b0;
      r_cfg_pending <= 1'b0;
      r_rx_en       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_newer <= w_newer_nxt;
      if (bus.cfg_wr) begin
        r_sh_par_en   <= bus.cfg_par_en;
        r_sh_par_typ  <= bus.cfg_par_typ;
        r_sh_prescale <= bus.cfg_prescale;
      end
      if (r_state == S_APPLY) begin
        r_par_en     <= r_sh_par_en;
        r_par_typ    <= r_sh_par_typ;
        r_prescale   <= r_sh_prescale;
        r_settle_cnt <= SETTLE_LAST;
      end else if ((r_state == S_SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - SW'(1);
      end
      r_cfg_ack     <= (w_state_nxt == S_APPLY);
      r_rx_en       <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_WAIT);
      r_cfg_pending <= (w_state_nxt == S_WAIT) || w_newer_nxt;
    end
  end

  // FIFO control: a full FIFO still accepts a word when the head leaves in the same cycle.
  always_comb begin
    w_pop       = r_out_valid && bus.out_ready;
    w_push      = bus.rx_data_valid && (!r_full || bus.out_ready);
    w_ovr       = bus.rx_data_valid && r_full && !bus.out_ready;
    w_count_nxt = r_count + OW'(w_push) - OW'(w_pop);
  end

  // FIFO storage, pointers and registered status flags; no bypass from rx_data to out_data.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= bus.rx_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_full      <= (w_count_nxt == DEPTH_CNT);
    end
  end

  // Error and overrun statistics.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_par_cnt <= '0;
      r_stp_cnt <= '0;
      r_ovr_cnt <= '0;
    end else begin
      r_par_cnt <= f_cnt_nxt(r_par_cnt, bus.rx_par_err, bus.cnt_clr);
      r_stp_cnt <= f_cnt_nxt(r_stp_cnt, bus.rx_stp_err, bus.cnt_clr);
      r_ovr_cnt <= f_cnt_nxt(r_ovr_cnt, w_ovr, bus.cnt_clr);
    end
  end

  assign bus.cfg_pending = r_cfg_pending;
  assign bus.cfg_ack     = r_cfg_ack;
  assign bus.PAR_EN      = r_par_en;
  assign bus.PAR_TYP     = r_par_typ;
  assign bus.Prescale    = r_prescale;
  assign bus.rx_en       = r_rx_en;
  // Head is read straight from the register array at the read pointer.
  assign bus.out_data    = r_mem[r_rptr];
  assign bus.out_valid   = r_out_valid;
  assign bus.fifo_full   = r_full;
  assign bus.par_err_cnt = r_par_cnt;
  assign bus.stp_err_cnt = r_stp_cnt;
  assign bus.ovr_cnt     = r_ovr_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: vector table, hand-written config/reset/counter sequences, and random FIFO traffic.
// Latency: inputs change 1ns after a rising edge; outputs are sampled 1ns after the next rising edge.
// Backpressure: out_ready is driven from vectors or randomly; a queue model predicts FIFO and counters.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  uart_rx_ctrl #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(4), .CNT_WIDTH(CW),
    .PRESCALE_RST(6'd8), .SETTLE_CYCLES(2)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       vld;
    logic [7:0] d;
    logic       rdy, pe, se, clr;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_full;
    logic [7:0] e_par, e_stp, e_ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.cfg_wr = 0; bus.cfg_par_en = 0; bus.cfg_par_typ = 0; bus.cfg_prescale = 0;
    bus.rx_busy = 0; bus.rx_data = 0; bus.rx_data_valid = 0;
    bus.rx_par_err = 0; bus.rx_stp_err = 0; bus.out_ready = 0; bus.cnt_clr = 0;
  endtask

  task automatic v(input logic vld, input logic [7:0] d, input logic rdy, input logic pe,
                   input logic se, input logic clr, input logic ev, input logic [7:0] ed,
                   input logic ef, input logic [7:0] ep, input logic [7:0] es, input logic [7:0] eo);
    vec_t r;
    r.vld = vld; r.d = d; r.rdy = rdy; r.pe = pe; r.se = se; r.clr = clr;
    r.e_valid = ev; r.e_data = ed; r.e_full = ef; r.e_par = ep; r.e_stp = es; r.e_ovr = eo;
    tbl.push_back(r);
  endtask

  task automatic cfg_req(input logic pe, input logic pt, input logic [5:0] ps);
    bus.cfg_wr = 1; bus.cfg_par_en = pe; bus.cfg_par_typ = pt; bus.cfg_prescale = ps;
  endtask

  // Counts cfg_ack pulses over a fixed window.
  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.cfg_ack === 1'b1) acks++;
    end
  endtask

  int acks;
  int q[$];
  int m_par, m_stp, m_ovr;

  initial begin
    // FIFO fill/overrun, simultaneous push/pop at full, push with errors, clear, no bypass.
    //  vld  d     rdy pe se clr | valid data  full par stp ovr
    v(1, 'h11, 0, 0, 0, 0,   1, 'h11, 0, 0, 0, 0);
    v(1, 'h12, 0, 0, 0, 0,   1, 'h11, 0, 0, 0, 0);
    v(1, 'h13, 0, 0, 0, 0,   1, 'h11, 0, 0, 0, 0);
    v(1, 'h14, 0, 0, 0, 0,   1, 'h11, 1, 0, 0, 0);
    v(1, 'h15, 0, 0, 0, 0,   1, 'h11, 1, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   1, 'h12, 0, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   1, 'h13, 0, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   1, 'h14, 0, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   0, 'h00, 0, 0, 0, 1);
    v(1, 'h01, 0, 0, 0, 0,   1, 'h01, 0, 0, 0, 1);
    v(1, 'h02, 0, 0, 0, 0,   1, 'h01, 0, 0, 0, 1);
    v(1, 'h03, 0, 0, 0, 0,   1, 'h01, 0, 0, 0, 1);
    v(1, 'h04, 0, 0, 0, 0,   1, 'h01, 1, 0, 0, 1);
    v(1, 'hAA, 1, 0, 0, 0,   1, 'h02, 1, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   1, 'h03, 0, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   1, 'h04, 0, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   1, 'hAA, 0, 0, 0, 1);
    v(0, 'h00, 1, 0, 0, 0,   0, 'h00, 0, 0, 0, 1);
    v(1, 'h5A, 0, 1, 1, 0,   1, 'h5A, 0, 1, 1, 1);
    v(0, 'h00, 1, 0, 0, 1,   0, 'h00, 0, 0, 0, 0);
    v(1, 'h77, 1, 0, 0, 0,   1, 'h77, 0, 0, 0, 0);
    v(0, 'h00, 1, 0, 0, 0,   0, 'h00, 0, 0, 0, 0);

    // Reset held for three cycles.
    quiet();
    rst = 1;
    repeat (3) step();
    chk("rst_par_en",   32'(bus.PAR_EN), 1);
    chk("rst_par_typ",  32'(bus.PAR_TYP), 0);
    chk("rst_prescale", 32'(bus.Prescale), 8);
    chk("rst_valid",    32'(bus.out_valid), 0);
    chk("rst_full",     32'(bus.fifo_full), 0);
    chk("rst_data",     32'(bus.out_data), 0);
    chk("rst_cnts",     32'({bus.par_err_cnt, bus.stp_err_cnt, bus.ovr_cnt}), 0);
    chk("rst_rx_en",    32'(bus.rx_en), 0);
    chk("rst_pending",  32'(bus.cfg_pending), 0);
    chk("rst_ack",      32'(bus.cfg_ack), 0);
    rst = 0;
    step();
    chk("rel_rx_en", 32'(bus.rx_en), 1);

    // Table-driven FIFO vectors.
    foreach (tbl[i]) begin
      bus.rx_data_valid = tbl[i].vld; bus.rx_data = tbl[i].d; bus.out_ready = tbl[i].rdy;
      bus.rx_par_err = tbl[i].pe; bus.rx_stp_err = tbl[i].se; bus.cnt_clr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d_full", i), 32'(bus.fifo_full), 32'(tbl[i].e_full));
      chk($sformatf("vec%0d_par", i), 32'(bus.par_err_cnt), 32'(tbl[i].e_par));
      chk($sformatf("vec%0d_stp", i), 32'(bus.stp_err_cnt), 32'(tbl[i].e_stp));
      chk($sformatf("vec%0d_ovr", i), 32'(bus.ovr_cnt), 32'(tbl[i].e_ovr));
    end
    quiet();

    // Deferred config while the receiver is busy.
    bus.rx_busy = 1;
    cfg_req(0, 1, 6'd16);
    step();
    bus.cfg_wr = 0;
    step();
    chk("def_pending",  32'(bus.cfg_pending), 1);
    chk("def_prescale", 32'(bus.Prescale), 8);
    chk("def_par_en",   32'(bus.PAR_EN), 1);
    chk("def_rx_en",    32'(bus.rx_en), 1);
    chk("def_ack",      32'(bus.cfg_ack), 0);
    bus.rx_busy = 0;                        // cycle T
    step();                                 // T+1
    chk("def_ack_t1",   32'(bus.cfg_ack), 1);
    chk("def_rxen_t1",  32'(bus.rx_en), 0);
    chk("def_ps_t1",    32'(bus.Prescale), 8);
    step();                                 // T+2
    chk("def_ack_t2",   32'(bus.cfg_ack), 0);
    chk("def_ps_t2",    32'(bus.Prescale), 16);
    chk("def_pe_t2",    32'(bus.PAR_EN), 0);
    chk("def_pt_t2",    32'(bus.PAR_TYP), 1);
    chk("def_rxen_t2",  32'(bus.rx_en), 0);
    step();                                 // T+3
    chk("def_rxen_t3",  32'(bus.rx_en), 0);
    step();                                 // T+4
    chk("def_rxen_t4",  32'(bus.rx_en), 1);
    chk("def_pend_t4",  32'(bus.cfg_pending), 0);

    // Last write wins while waiting.
    bus.rx_busy = 1;
    cfg_req(1, 0, 6'd16);
    step();
    cfg_req(1, 0, 6'd32);
    step();
    bus.cfg_wr = 0;
    bus.rx_busy = 0;
    count_acks(8, acks);
    chk("lww_acks",     32'(acks), 1);
    chk("lww_prescale", 32'(bus.Prescale), 32);
    chk("lww_par_en",   32'(bus.PAR_EN), 1);
    chk("lww_pending",  32'(bus.cfg_pending), 0);
    chk("lww_rx_en",    32'(bus.rx_en), 1);

    // Request arriving during APPLY is applied by a second pass through WAIT.
    cfg_req(1, 0, 6'd20);
    step();                                 // WAIT
    bus.cfg_wr = 0;
    step();                                 // APPLY
    chk("reapply_ack1", 32'(bus.cfg_ack), 1);
    cfg_req(1, 1, 6'd24);
    step();                                 // SETTLE
    bus.cfg_wr = 0;
    chk("reapply_pend", 32'(bus.cfg_pending), 1);
    chk("reapply_ps1",  32'(bus.Prescale), 20);
    chk("reapply_rxen", 32'(bus.rx_en), 0);
    count_acks(10, acks);
    chk("reapply_acks", 32'(acks), 1);
    chk("reapply_ps2",  32'(bus.Prescale), 24);
    chk("reapply_pt2",  32'(bus.PAR_TYP), 1);
    chk("reapply_pend2", 32'(bus.cfg_pending), 0);

    // Counter saturation and clear-with-event.
    bus.rx_par_err = 1;
    repeat (300) step();
    bus.rx_par_err = 0;
    chk("sat_par", 32'(bus.par_err_cnt), 255);
    bus.cnt_clr = 1; bus.rx_stp_err = 1;
    step();
    quiet();
    chk("clr_stp", 32'(bus.stp_err_cnt), 1);
    chk("clr_par", 32'(bus.par_err_cnt), 0);

    // Reset in the middle of traffic and a pending config.
    bus.rx_data_valid = 1; bus.rx_data = 'h3C; bus.rx_par_err = 1;
    step();
    bus.rx_data_valid = 0; bus.rx_par_err = 0;
    bus.rx_busy = 1;
    cfg_req(0, 1, 6'd40);
    step();
    bus.cfg_wr = 0;
    chk("mid_pre_valid", 32'(bus.out_valid), 1);
    rst = 1;
    step();
    chk("mid_valid",    32'(bus.out_valid), 0);
    chk("mid_data",     32'(bus.out_data), 0);
    chk("mid_cnts",     32'({bus.par_err_cnt, bus.stp_err_cnt, bus.ovr_cnt}), 0);
    chk("mid_prescale", 32'(bus.Prescale), 8);
    chk("mid_par",      32'({bus.PAR_EN, bus.PAR_TYP}), 2);
    chk("mid_pending",  32'(bus.cfg_pending), 0);
    chk("mid_rx_en",    32'(bus.rx_en), 0);
    rst = 0;
    bus.rx_busy = 0;
    count_acks(6, acks);
    chk("mid_no_ack",   32'(acks), 0);
    chk("mid_ps_keep",  32'(bus.Prescale), 8);
    chk("mid_rx_en1",   32'(bus.rx_en), 1);

    // Random traffic against a queue-based model of the buffer and counters.
    q.delete();
    m_par = 0; m_stp = 0; m_ovr = 0;
    for (int c = 0; c < 800; c++) begin
      int vld, rdy, pe, se, clr, d, ovr;
      bit full;
      vld = ($urandom_range(0, 9) < 6) ? 1 : 0;
      rdy = ($urandom_range(0, 9) < ((c / 100) % 2 == 0 ? 3 : 7)) ? 1 : 0;
      pe  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      se  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      clr = ($urandom_range(0, 63) == 0) ? 1 : 0;
      d   = int'($urandom_range(0, 255));
      bus.rx_data_valid = vld[0]; bus.out_ready = rdy[0]; bus.rx_par_err = pe[0];
      bus.rx_stp_err = se[0]; bus.cnt_clr = clr[0]; bus.rx_data = 8'(d);
      bus.rx_busy = 1'($urandom_range(0, 1));

      full = (q.size() == 4);
      ovr  = (vld == 1 && full && rdy == 0) ? 1 : 0;
      if (q.size() > 0 && rdy == 1) void'(q.pop_front());
      if (vld == 1 && (!full || rdy == 1)) q.push_back(d);
      m_par = clr ? pe  : ((m_par + pe  > 255) ? 255 : m_par + pe);
      m_stp = clr ? se  : ((m_stp + se  > 255) ? 255 : m_stp + se);
      m_ovr = clr ? ovr : ((m_ovr + ovr > 255) ? 255 : m_ovr + ovr);

      step();
      chk("rnd_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      chk("rnd_full",  32'(bus.fifo_full), 32'(q.size() == 4));
      if (q.size() > 0) chk("rnd_data", 32'(bus.out_data), 32'(q[0]));
      chk("rnd_par",   32'(bus.par_err_cnt), 32'(m_par));
      chk("rnd_stp",   32'(bus.stp_err_cnt), 32'(m_stp));
      chk("rnd_ovr",   32'(bus.ovr_cnt), 32'(m_ovr));
      chk("rnd_rx_en", 32'({bus.rx_en, bus.cfg_ack}), 2);
    end
    quiet();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
